// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - independent predictor and mismatch monitor for a loadable wrapping counter
// Optional first-mismatch snapshot registers are built when COUNTER_CHECKER_SNAPSHOT_EN is defined.
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int HALT_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic [WIDTH-1:0]     dout,
  output logic                 locked,
  output logic [WIDTH-1:0]     exp_val,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_obs
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     W_ONE = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] C_ONE = ERR_CNT_W'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic                 pulse_q, pulse_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 locked_q;
  logic                 mismatch;
  logic [WIDTH-1:0]     resync_val;

  // Resyncing to the observed value makes a single counter jump cost exactly one error.
  assign mismatch   = (state_q == TRACK) && (dout != exp_q);
  assign resync_val = load ? din : dout + W_ONE;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    case (state_q)
      ACQUIRE: begin
        exp_d   = resync_val;
        state_d = TRACK;
      end
      TRACK: begin
        if (mismatch) begin
          pulse_d  = 1'b1;
          sticky_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + C_ONE;
          exp_d = resync_val;
          if (HALT_ON_ERR != 0) state_d = HALT;
        end else begin
          exp_d = load ? din : exp_q + W_ONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACQUIRE;
      exp_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      locked_q <= (state_d == TRACK);
    end
  end

  assign locked     = locked_q;
  assign exp_val    = exp_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

`ifdef COUNTER_CHECKER_SNAPSHOT_EN
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_obs_q;

  // Only the first mismatch since reset is captured; sticky marks that it already happened.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else if (mismatch && !sticky_q) begin
      first_exp_q <= exp_q;
      first_obs_q <= dout;
    end
  end

  assign first_exp = first_exp_q;
  assign first_obs = first_obs_q;
`else
  assign first_exp = '0;
  assign first_obs = '0;
`endif

endmodule
